// File: rtl/mem_port_pkg.sv
// Shared types for the mem_port load/store unit: access-size encodings,
// controller states and small size-decode helpers.
package mem_port_pkg;

    localparam int BUS_AW_DEFAULT = 30;

    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5
    } mem_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    // Unsigned sizes only make sense for loads.
    function automatic logic size_illegal(input logic [2:0] size, input logic we);
        logic bad;
        case (size)
            MEM_B, MEM_H, MEM_W: bad = 1'b0;
            MEM_BU, MEM_HU:      bad = we;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic size_misaligned(input logic [2:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            MEM_H, MEM_HU: mis = (off == 2'd3);
            MEM_W:         mis = (off != 2'd0);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] size);
        logic [3:0] mask;
        case (size)
            MEM_B, MEM_BU: mask = 4'b0001;
            MEM_H, MEM_HU: mask = 4'b0011;
            default:       mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_port_if.sv
// Word-wide valid/ready data bus with a single outstanding beat.
interface mem_port_if
    import mem_port_pkg::*;
#(
    parameter int BUS_AW = BUS_AW_DEFAULT
);
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [BUS_AW-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_port_lane_align.sv
// Byte-lane steering: enables and shifted store data for both beats, and the
// two-word read merge with sign/zero extension.
module mem_lane_align
    import mem_port_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wd0,
    output logic [31:0] wd1,
    output logic [31:0] rdata
);
    logic [4:0]  sh_s;
    logic [5:0]  rsh_s;
    logic [7:0]  mask_s;
    logic [31:0] merged_s;

    // Lane masks span both words; shifts of 32 yield zero so off==0 needs no special case.
    always_comb begin
        sh_s     = {off, 3'b000};
        rsh_s    = 6'd32 - {1'b0, sh_s};
        mask_s   = {4'b0000, size_mask(size)} << off;
        be0      = mask_s[3:0];
        be1      = mask_s[7:4];
        wd0      = wdata << sh_s;
        wd1      = wdata >> rsh_s;
        merged_s = (lo >> sh_s) | (hi << rsh_s);
        case (size)
            MEM_B:   rdata = {{24{merged_s[7]}}, merged_s[7:0]};
            MEM_BU:  rdata = {24'h000000, merged_s[7:0]};
            MEM_H:   rdata = {{16{merged_s[15]}}, merged_s[15:0]};
            MEM_HU:  rdata = {16'h0000, merged_s[15:0]};
            default: rdata = merged_s;
        endcase
    end
endmodule

// File: rtl/mem_port.sv
// Load/store unit: accepts one core access, issues one or two bus beats and
// returns the extended load result with a one-cycle done pulse.
module mem_port
    import mem_port_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int BUS_AW           = BUS_AW_DEFAULT
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               core_req,
    input  logic               core_we,
    input  logic [31:0]        core_addr,
    input  logic [2:0]         core_size,
    input  logic [31:0]        core_wdata,
    output logic [31:0]        core_rdata,
    output logic               core_done,
    output logic               core_err,
    output logic               core_busy,
    mem_port_if.master         bus_if
);
    state_t            state_r;
    logic [1:0]        off_r;
    logic [BUS_AW-1:0] wa_r;
    logic [2:0]        size_r;
    logic              we_r;
    logic [31:0]       wdata_r;
    logic [31:0]       lo_r;
    logic              split_r;

    logic [1:0]        sel_off_s;
    logic [2:0]        sel_size_s;
    logic [31:0]       sel_wdata_s;
    logic [31:0]       merge_lo_s;
    logic [31:0]       merge_hi_s;
    logic              illegal_s;
    logic              mis_s;
    logic [3:0]        be0_s;
    logic [3:0]        be1_s;
    logic [31:0]       wd0_s;
    logic [31:0]       wd1_s;
    logic [31:0]       ext_s;

    // In IDLE the aligner sees the incoming request so beat 0 can be registered at acceptance.
    always_comb begin
        illegal_s = size_illegal(core_size, core_we);
        mis_s     = size_misaligned(core_size, core_addr[1:0]);
        if (state_r == ST_IDLE) begin
            sel_off_s   = core_addr[1:0];
            sel_size_s  = core_size;
            sel_wdata_s = core_wdata;
        end else begin
            sel_off_s   = off_r;
            sel_size_s  = size_r;
            sel_wdata_s = wdata_r;
        end
        if (state_r == ST_WAIT1) begin
            merge_lo_s = lo_r;
            merge_hi_s = bus_if.bus_rdata;
        end else begin
            merge_lo_s = bus_if.bus_rdata;
            merge_hi_s = 32'h0000_0000;
        end
    end

    mem_lane_align u_align (
        .off   (sel_off_s),
        .size  (sel_size_s),
        .wdata (sel_wdata_s),
        .lo    (merge_lo_s),
        .hi    (merge_hi_s),
        .be0   (be0_s),
        .be1   (be1_s),
        .wd0   (wd0_s),
        .wd1   (wd1_s),
        .rdata (ext_s)
    );

    // Controller FSM with all core and bus outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            off_r            <= 2'd0;
            wa_r             <= '0;
            size_r           <= 3'd0;
            we_r             <= 1'b0;
            wdata_r          <= 32'h0000_0000;
            lo_r             <= 32'h0000_0000;
            split_r          <= 1'b0;
            core_rdata       <= 32'h0000_0000;
            core_done        <= 1'b0;
            core_err         <= 1'b0;
            core_busy        <= 1'b0;
            bus_if.bus_valid <= 1'b0;
            bus_if.bus_we    <= 1'b0;
            bus_if.bus_addr  <= '0;
            bus_if.bus_be    <= 4'b0000;
            bus_if.bus_wdata <= 32'h0000_0000;
        end else begin
            core_done <= 1'b0;
            core_err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (core_req) begin
                        off_r     <= core_addr[1:0];
                        wa_r      <= BUS_AW'(core_addr[31:2]);
                        size_r    <= core_size;
                        we_r      <= core_we;
                        wdata_r   <= core_wdata;
                        split_r   <= mis_s;
                        core_busy <= 1'b1;
                        if (illegal_s || (mis_s && !SPLIT_MISALIGNED)) begin
                            state_r   <= ST_FIN;
                            core_done <= 1'b1;
                            core_err  <= 1'b1;
                        end else begin
                            state_r          <= ST_ISSUE0;
                            bus_if.bus_valid <= 1'b1;
                            bus_if.bus_we    <= core_we;
                            bus_if.bus_addr  <= BUS_AW'(core_addr[31:2]);
                            bus_if.bus_be    <= be0_s;
                            bus_if.bus_wdata <= wd0_s;
                        end
                    end
                end
                ST_ISSUE0: begin
                    if (bus_if.bus_ready) begin
                        bus_if.bus_valid <= 1'b0;
                        state_r          <= ST_WAIT0;
                    end
                end
                ST_WAIT0: begin
                    if (bus_if.bus_rvalid) begin
                        lo_r <= bus_if.bus_rdata;
                        if (split_r) begin
                            state_r          <= ST_ISSUE1;
                            bus_if.bus_valid <= 1'b1;
                            bus_if.bus_addr  <= wa_r + BUS_AW'(1);
                            bus_if.bus_be    <= be1_s;
                            bus_if.bus_wdata <= wd1_s;
                        end else begin
                            state_r   <= ST_FIN;
                            core_done <= 1'b1;
                            if (!we_r) begin
                                core_rdata <= ext_s;
                            end
                        end
                    end
                end
                ST_ISSUE1: begin
                    if (bus_if.bus_ready) begin
                        bus_if.bus_valid <= 1'b0;
                        state_r          <= ST_WAIT1;
                    end
                end
                ST_WAIT1: begin
                    if (bus_if.bus_rvalid) begin
                        state_r   <= ST_FIN;
                        core_done <= 1'b1;
                        if (!we_r) begin
                            core_rdata <= ext_s;
                        end
                    end
                end
                ST_FIN: begin
                    state_r   <= ST_IDLE;
                    core_busy <= 1'b0;
                end
                default: begin
                    state_r          <= ST_IDLE;
                    core_busy        <= 1'b0;
                    bus_if.bus_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port.sv
// Directed self-checking bench for mem_port: one splitting instance and one
// instance with misaligned splitting disabled.
module tb_mem_port;
    logic        clk;
    logic        rst_n;
    logic        core_req, core_req1;
    logic        core_we;
    logic [31:0] core_addr;
    logic [2:0]  core_size;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata, core_rdata1;
    logic        core_done, core_done1;
    logic        core_err, core_err1;
    logic        core_busy, core_busy1;
    logic        seen_valid1;
    int          vectors;
    int          miscompares;

    mem_port_if #(.BUS_AW(30)) bus0 ();
    mem_port_if #(.BUS_AW(30)) bus1 ();

    mem_port #(.SPLIT_MISALIGNED(1'b1), .BUS_AW(30)) dut0 (
        .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_size(core_size), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_done(core_done), .core_err(core_err),
        .core_busy(core_busy), .bus_if(bus0)
    );

    mem_port #(.SPLIT_MISALIGNED(1'b0), .BUS_AW(30)) dut1 (
        .clk(clk), .rst_n(rst_n), .core_req(core_req1), .core_we(core_we),
        .core_addr(core_addr), .core_size(core_size), .core_wdata(core_wdata),
        .core_rdata(core_rdata1), .core_done(core_done1), .core_err(core_err1),
        .core_busy(core_busy1), .bus_if(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus1.bus_ready  = 1'b0;
    assign bus1.bus_rvalid = 1'b0;
    assign bus1.bus_rdata  = 32'h0000_0000;

    always @(posedge clk) begin
        if (!rst_n) seen_valid1 <= 1'b0;
        else if (bus1.bus_valid) seen_valid1 <= 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] addr, input logic [2:0] size,
                         input logic we, input logic [31:0] wdata);
        core_addr  = addr;
        core_size  = size;
        core_we    = we;
        core_wdata = wdata;
        core_req   = 1'b1;
        step();
        core_req   = 1'b0;
    endtask

    // Ack the current beat, then return rdata one cycle later.
    task automatic beat(input logic [31:0] rdata);
        bus0.bus_ready = 1'b1;
        step();
        bus0.bus_ready  = 1'b0;
        bus0.bus_rvalid = 1'b1;
        bus0.bus_rdata  = rdata;
        step();
        bus0.bus_rvalid = 1'b0;
    endtask

    task automatic single_load(input string tag, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] rdata, input logic [3:0] exp_be,
                               input logic [31:0] exp_rdata);
        start(addr, size, 1'b0, 32'h0);
        chk({tag, "_be"}, {28'h0, bus0.bus_be}, {28'h0, exp_be});
        beat(rdata);
        chk({tag, "_done"}, {31'h0, core_done}, 32'd1);
        chk({tag, "_rdata"}, core_rdata, exp_rdata);
        step();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        core_req = 1'b0; core_req1 = 1'b0; core_we = 1'b0;
        core_addr = 32'h0; core_size = 3'd0; core_wdata = 32'h0;
        bus0.bus_ready = 1'b0; bus0.bus_rvalid = 1'b0; bus0.bus_rdata = 32'h0;
        step(); step();
        chk("rst_valid", {31'h0, bus0.bus_valid}, 32'd0);
        chk("rst_be", {28'h0, bus0.bus_be}, 32'd0);
        chk("rst_done", {31'h0, core_done}, 32'd0);
        chk("rst_busy", {31'h0, core_busy}, 32'd0);
        chk("rst_rdata", core_rdata, 32'h0);
        rst_n = 1'b1;
        step();

        // Aligned LW with cycle-by-cycle latency checks
        start(32'h0000_0100, 3'd2, 1'b0, 32'h0);
        chk("lw_valid", {31'h0, bus0.bus_valid}, 32'd1);
        chk("lw_addr", {2'b00, bus0.bus_addr}, 32'h40);
        chk("lw_be", {28'h0, bus0.bus_be}, 32'hF);
        chk("lw_busy", {31'h0, core_busy}, 32'd1);
        bus0.bus_ready = 1'b1;
        step();
        bus0.bus_ready = 1'b0;
        chk("lw_valid_drop", {31'h0, bus0.bus_valid}, 32'd0);
        chk("lw_nodone2", {31'h0, core_done}, 32'd0);
        bus0.bus_rvalid = 1'b1;
        bus0.bus_rdata  = 32'hDEAD_BEEF;
        step();
        bus0.bus_rvalid = 1'b0;
        chk("lw_done3", {31'h0, core_done}, 32'd1);
        chk("lw_err", {31'h0, core_err}, 32'd0);
        chk("lw_rdata", core_rdata, 32'hDEAD_BEEF);
        core_req = 1'b1;            // request during FIN must be ignored
        step();
        core_req = 1'b0;
        chk("lw_done_pulse", {31'h0, core_done}, 32'd0);
        chk("fin_req_ignored", {31'h0, core_busy}, 32'd0);
        chk("fin_req_novalid", {31'h0, bus0.bus_valid}, 32'd0);

        single_load("lb", 32'h0000_0103, 3'd0, 32'h80FF_FFFF, 4'b1000, 32'hFFFF_FF80);
        single_load("lbu", 32'h0000_0103, 3'd4, 32'h80FF_FFFF, 4'b1000, 32'h0000_0080);
        single_load("lh1", 32'h0000_0011, 3'd1, 32'h00F0_0F00, 4'b0110, 32'hFFFF_F00F);

        // SH: lane-positioned store data, core_rdata retained
        start(32'h0000_0202, 3'd1, 1'b1, 32'h1234_ABCD);
        chk("sh_be", {28'h0, bus0.bus_be}, 32'hC);
        chk("sh_wdata_hi", {16'h0, bus0.bus_wdata[31:16]}, 32'hABCD);
        chk("sh_we", {31'h0, bus0.bus_we}, 32'd1);
        chk("sh_addr", {2'b00, bus0.bus_addr}, 32'h80);
        beat(32'h5555_5555);
        chk("sh_done", {31'h0, core_done}, 32'd1);
        chk("sh_rdata_kept", core_rdata, 32'hFFFF_F00F);
        step();

        // Misaligned LW split across two words
        start(32'h0000_07FD, 3'd2, 1'b0, 32'h0);
        chk("mlw_addr0", {2'b00, bus0.bus_addr}, 32'h1FF);
        chk("mlw_be0", {28'h0, bus0.bus_be}, 32'hE);
        beat(32'hAABB_CCDD);
        chk("mlw_valid1", {31'h0, bus0.bus_valid}, 32'd1);
        chk("mlw_addr1", {2'b00, bus0.bus_addr}, 32'h200);
        chk("mlw_be1", {28'h0, bus0.bus_be}, 32'h1);
        chk("mlw_nodone", {31'h0, core_done}, 32'd0);
        beat(32'h1122_3344);
        chk("mlw_done5", {31'h0, core_done}, 32'd1);
        chk("mlw_rdata", core_rdata, 32'h44AA_BBCC);
        step();

        // Misaligned SW: beat data split over both words
        start(32'h0000_0102, 3'd2, 1'b1, 32'h8765_4321);
        chk("msw_wd0", bus0.bus_wdata, 32'h4321_0000);
        beat(32'h0);
        chk("msw_be1", {28'h0, bus0.bus_be}, 32'h3);
        chk("msw_wd1", bus0.bus_wdata, 32'h0000_8765);
        beat(32'h0);
        chk("msw_done", {31'h0, core_done}, 32'd1);
        step();

        // LH at 0xFFFFFFFF wraps to word 0 on the second beat
        start(32'hFFFF_FFFF, 3'd1, 1'b0, 32'h0);
        chk("wrap_addr0", {2'b00, bus0.bus_addr}, 32'h3FFF_FFFF);
        chk("wrap_be0", {28'h0, bus0.bus_be}, 32'h8);
        beat(32'h1234_5678);
        chk("wrap_addr1", {2'b00, bus0.bus_addr}, 32'h0);
        chk("wrap_be1", {28'h0, bus0.bus_be}, 32'h1);
        beat(32'hAAAA_55CC);
        chk("wrap_rdata", core_rdata, 32'hFFFF_CC12);
        step();

        // Same access with splitting disabled: immediate error, no bus access
        core_addr = 32'hFFFF_FFFF; core_size = 3'd1; core_we = 1'b0;
        core_req1 = 1'b1;
        step();
        core_req1 = 1'b0;
        chk("nosplit_done1", {31'h0, core_done1}, 32'd1);
        chk("nosplit_err", {31'h0, core_err1}, 32'd1);
        step();
        chk("nosplit_pulse", {31'h0, core_done1}, 32'd0);
        chk("nosplit_novalid", {31'h0, seen_valid1}, 32'd0);

        // Illegal sizes on the splitting instance
        start(32'h0000_0000, 3'd3, 1'b0, 32'h0);
        chk("ill3_done", {31'h0, core_done}, 32'd1);
        chk("ill3_err", {31'h0, core_err}, 32'd1);
        chk("ill3_novalid", {31'h0, bus0.bus_valid}, 32'd0);
        step();
        start(32'h0000_0000, 3'd4, 1'b1, 32'h0);
        chk("illbu_store_err", {31'h0, core_err}, 32'd1);
        step();

        // Stall in ISSUE0, then reset mid-operation
        start(32'h0000_0010, 3'd2, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'h0, bus0.bus_valid}, 32'd1);
            chk("stall_addr", {2'b00, bus0.bus_addr}, 32'h4);
            chk("stall_be", {28'h0, bus0.bus_be}, 32'hF);
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_valid", {31'h0, bus0.bus_valid}, 32'd0);
        chk("abort_busy", {31'h0, core_busy}, 32'd0);
        bus0.bus_rvalid = 1'b1;
        bus0.bus_rdata  = 32'hFFFF_FFFF;
        step();
        bus0.bus_rvalid = 1'b0;
        chk("late_rvalid_nodone", {31'h0, core_done}, 32'd0);
        chk("late_rvalid_busy", {31'h0, core_busy}, 32'd0);
        chk("late_rvalid_rdata", core_rdata, 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
